// File: rtl/pwr_sequencer.sv
// Power/authority sequencer: OFF/ON/PEND_OFF/OVRSPD state machine that gates
//   balance_cntrl through pwr_up and raises overspeed and battery-low alerts.
// Latency: every output is registered and updates on the clock edge after its
//   cause. A button edge reaches pwr_up 3 clocks later (2 sync + 1 register).
// Backpressure: none. The inputs are level/strobe sampled and nothing is queued.
//
// Ports:
//   clk, rst_n    system clock, asynchronous active-low reset
//   tgglMd        raw rider button level (asynchronous, active-high press)
//   vld           one-cycle strobe, new sample set (too_fast, batt) valid
//   rider_off     high when the load cells see no rider
//   too_fast      overspeed status from balance_cntrl
//   batt[11:0]    unsigned battery reading, valid with vld
//   pwr_up        enables balance_cntrl
//   ovr_spd       overspeed alert
//   batt_low      battery-low alert
//   state_o[1:0]  OFF=0, ON=1, PEND_OFF=2, OVRSPD=3

module pwr_sequencer #(
    parameter int unsigned IDLE_TMO_W = 26,
    parameter int unsigned FAST_CNT   = 4,
    parameter logic [11:0] BATT_THRES = 12'h800
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tgglMd,
    input  logic        vld,
    input  logic        rider_off,
    input  logic        too_fast,
    input  logic [11:0] batt,
    output logic        pwr_up,
    output logic        ovr_spd,
    output logic        batt_low,
    output logic [1:0]  state_o
);

    localparam logic [1:0] ST_OFF      = 2'd0;
    localparam logic [1:0] ST_ON       = 2'd1;
    localparam logic [1:0] ST_PEND_OFF = 2'd2;
    localparam logic [1:0] ST_OVRSPD   = 2'd3;

    localparam int unsigned      CNT_W    = $clog2(FAST_CNT + 1);
    // The transition fires on the strobe that would take the count to
    // FAST_CNT, so the comparison is against the value one short of it.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FAST_CNT - 1);

    // ------------------------------------------------------------------
    // Button synchronizer and rising-edge detect
    // ------------------------------------------------------------------
    logic sync1_q;
    logic sync2_q;
    logic hist_q;
    logic press;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            hist_q  <= 1'b0;
        end else begin
            sync1_q <= tgglMd;
            sync2_q <= sync1_q;
            hist_q  <= sync2_q;
        end
    end

    // One-clock pulse per rising edge; holding the button gives one pulse.
    assign press = sync2_q & ~hist_q;

    // ------------------------------------------------------------------
    // State, counters and registered outputs
    // ------------------------------------------------------------------
    logic [1:0]            state_q,    state_d;
    logic [CNT_W-1:0]      spd_cnt_q,  spd_cnt_d;
    logic [IDLE_TMO_W-1:0] idle_q,     idle_d;
    logic                  pwr_up_q,   pwr_up_d;
    logic                  ovr_spd_q,  ovr_spd_d;
    logic                  batt_low_q, batt_low_d;

    logic spd_hit;   // overspeed entry condition this cycle
    logic rec_hit;   // overspeed recovery condition this cycle
    logic idle_exp;  // idle timer terminal count with rider still off

    assign spd_hit  = vld &  too_fast & (spd_cnt_q == CNT_LAST);
    assign rec_hit  = vld & ~too_fast & (spd_cnt_q == CNT_LAST);
    assign idle_exp = rider_off & (&idle_q);

    // Next-state logic; the order of the if-chain encodes exit priority.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_OFF: begin
                if (press) state_d = ST_ON;
            end
            ST_ON: begin
                if (spd_hit)       state_d = ST_OVRSPD;
                else if (idle_exp) state_d = ST_OFF;
                else if (press)    state_d = ST_PEND_OFF;
            end
            ST_PEND_OFF: begin
                // Power-down is deferred until the rider has stepped off;
                // a second press cancels the request.
                if (spd_hit)        state_d = ST_OVRSPD;
                else if (rider_off) state_d = ST_OFF;
                else if (press)     state_d = ST_ON;
            end
            ST_OVRSPD: begin
                // Presses are deliberately dropped here so the rider cannot
                // request power-down while the platform is over speed.
                if (rec_hit) state_d = ST_ON;
            end
            default: state_d = ST_OFF;
        endcase
    end

    // One counter serves both directions: consecutive too_fast samples in
    // ON/PEND_OFF, consecutive good samples in OVRSPD. Any state change
    // restarts it so each phase counts from zero.
    always_comb begin
        spd_cnt_d = spd_cnt_q;
        if ((state_q == ST_OFF) || (state_d != state_q)) begin
            spd_cnt_d = '0;
        end else if (vld) begin
            if (state_q == ST_OVRSPD) begin
                spd_cnt_d = too_fast ? '0 : spd_cnt_q + CNT_W'(1);
            end else begin
                spd_cnt_d = too_fast ? spd_cnt_q + CNT_W'(1) : '0;
            end
        end
    end

    // Idle timer runs only while ON with no rider; expiry is handled by the
    // state logic, which leaves ON and therefore clears the timer.
    always_comb begin
        idle_d = '0;
        if ((state_q == ST_ON) && (state_d == ST_ON) && rider_off) begin
            idle_d = idle_q + IDLE_TMO_W'(1);
        end
    end

    // Outputs are decoded from the next state so they change on the same
    // edge as state_o.
    always_comb begin
        pwr_up_d   = (state_d != ST_OFF);
        ovr_spd_d  = (state_d == ST_OVRSPD);
        batt_low_d = batt_low_q;
        if (state_d == ST_OFF) begin
            batt_low_d = 1'b0;
        end else if (pwr_up_q && vld) begin
            // Gated on the registered pwr_up so the cycle that powers on
            // from OFF never samples batt.
            batt_low_d = (batt < BATT_THRES);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_OFF;
            spd_cnt_q  <= '0;
            idle_q     <= '0;
            pwr_up_q   <= 1'b0;
            ovr_spd_q  <= 1'b0;
            batt_low_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            spd_cnt_q  <= spd_cnt_d;
            idle_q     <= idle_d;
            pwr_up_q   <= pwr_up_d;
            ovr_spd_q  <= ovr_spd_d;
            batt_low_q <= batt_low_d;
        end
    end

    assign pwr_up   = pwr_up_q;
    assign ovr_spd  = ovr_spd_q;
    assign batt_low = batt_low_q;
    assign state_o  = state_q;

endmodule

// File: tb/tb_pwr_sequencer.sv
// Directed testbench for pwr_sequencer (IDLE_TMO_W=8, FAST_CNT=4).
// Inputs change on the falling edge; outputs are checked on the falling edge.
// Expected values are hand-derived from the sequencer behaviour.

module tb_pwr_sequencer;

    logic        clk;
    logic        rst_n;
    logic        tgglMd;
    logic        vld;
    logic        rider_off;
    logic        too_fast;
    logic [11:0] batt;
    logic        pwr_up;
    logic        ovr_spd;
    logic        batt_low;
    logic [1:0]  state_o;

    int vec_cnt = 0;
    int err_cnt = 0;

    pwr_sequencer #(
        .IDLE_TMO_W (8),
        .FAST_CNT   (4),
        .BATT_THRES (12'h800)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tgglMd    (tgglMd),
        .vld       (vld),
        .rider_off (rider_off),
        .too_fast  (too_fast),
        .batt      (batt),
        .pwr_up    (pwr_up),
        .ovr_spd   (ovr_spd),
        .batt_low  (batt_low),
        .state_o   (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        vec_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Rising edge on the button; state changes on the 3rd edge, then the
    // button is released long enough for the edge detector to re-arm.
    task automatic press_btn();
        tgglMd = 1'b1;
        tick(3);
        tgglMd = 1'b0;
        tick(3);
    endtask

    task automatic strobe(input logic tf, input logic [11:0] b);
        vld      = 1'b1;
        too_fast = tf;
        batt     = b;
        tick(1);
        vld      = 1'b0;
        too_fast = 1'b0;
        tick(1);
    endtask

    initial begin
        rst_n     = 1'b0;
        tgglMd    = 1'b0;
        vld       = 1'b0;
        rider_off = 1'b0;
        too_fast  = 1'b0;
        batt      = 12'hFFF;
        @(negedge clk);
        tick(2);

        // Reset state
        chk("rst_state",    12'(state_o),  12'd0);
        chk("rst_pwr_up",   12'(pwr_up),   12'd0);
        chk("rst_ovr_spd",  12'(ovr_spd),  12'd0);
        chk("rst_batt_low", 12'(batt_low), 12'd0);
        rst_n = 1'b1;
        tick(2);

        // 1: power on, 3-clock latency, held button gives one toggle
        tgglMd = 1'b1;
        tick(2);
        chk("t1_pwr_before", 12'(pwr_up),  12'd0);
        chk("t1_st_before",  12'(state_o), 12'd0);
        tick(1);
        chk("t1_pwr_on",     12'(pwr_up),  12'd1);
        chk("t1_st_on",      12'(state_o), 12'd1);
        tick(7);
        chk("t1_hold_st",    12'(state_o), 12'd1);
        tgglMd = 1'b0;
        tick(3);

        // 2: deferred power-down and cancel
        press_btn();
        chk("t2_pend_st",    12'(state_o), 12'd2);
        chk("t2_pend_pwr",   12'(pwr_up),  12'd1);
        rider_off = 1'b1;
        tick(1);
        chk("t2_off_st",     12'(state_o), 12'd0);
        chk("t2_off_pwr",    12'(pwr_up),  12'd0);
        rider_off = 1'b0;
        press_btn();
        chk("t2_on_again",   12'(state_o), 12'd1);
        press_btn();
        chk("t2_pend2",      12'(state_o), 12'd2);
        press_btn();
        chk("t2_cancel_st",  12'(state_o), 12'd1);
        chk("t2_cancel_pwr", 12'(pwr_up),  12'd1);

        // 3: overspeed entry needs 4 consecutive strobes, recovery 4 good ones
        strobe(1'b1, 12'hFFF);
        strobe(1'b1, 12'hFFF);
        strobe(1'b1, 12'hFFF);
        strobe(1'b0, 12'hFFF);
        chk("t3_broken_st",  12'(state_o), 12'd1);
        chk("t3_broken_ovr", 12'(ovr_spd), 12'd0);
        strobe(1'b1, 12'hFFF);
        strobe(1'b1, 12'hFFF);
        strobe(1'b1, 12'hFFF);
        chk("t3_three_st",   12'(state_o), 12'd1);
        strobe(1'b1, 12'hFFF);
        chk("t3_ovr_st",     12'(state_o), 12'd3);
        chk("t3_ovr_flag",   12'(ovr_spd), 12'd1);
        chk("t3_ovr_pwr",    12'(pwr_up),  12'd1);
        press_btn();
        chk("t3_press_ign",  12'(state_o), 12'd3);
        strobe(1'b0, 12'hFFF);
        strobe(1'b0, 12'hFFF);
        strobe(1'b0, 12'hFFF);
        chk("t3_rec3_st",    12'(state_o), 12'd3);
        strobe(1'b0, 12'hFFF);
        chk("t3_rec_st",     12'(state_o), 12'd1);
        chk("t3_rec_flag",   12'(ovr_spd), 12'd0);

        // 3b: overspeed wins from PEND_OFF as well
        press_btn();
        chk("t3b_pend",      12'(state_o), 12'd2);
        strobe(1'b1, 12'hFFF);
        strobe(1'b1, 12'hFFF);
        strobe(1'b1, 12'hFFF);
        strobe(1'b1, 12'hFFF);
        chk("t3b_ovr_st",    12'(state_o), 12'd3);
        strobe(1'b0, 12'hFFF);
        strobe(1'b0, 12'hFFF);
        strobe(1'b0, 12'hFFF);
        strobe(1'b0, 12'hFFF);
        chk("t3b_rec_st",    12'(state_o), 12'd1);

        // 4: idle timer, 255 clocks is not enough, 256 is
        rider_off = 1'b1;
        tick(255);
        chk("t4_255_st",     12'(state_o), 12'd1);
        rider_off = 1'b0;
        tick(1);
        rider_off = 1'b1;
        tick(255);
        chk("t4_run2_255",   12'(state_o), 12'd1);
        tick(1);
        chk("t4_idle_st",    12'(state_o), 12'd0);
        chk("t4_idle_pwr",   12'(pwr_up),  12'd0);
        rider_off = 1'b0;
        tick(1);

        // 5: battery threshold, hold, and clear on OFF
        strobe(1'b0, 12'h000);
        chk("t5_off_nosamp", 12'(batt_low), 12'd0);
        press_btn();
        chk("t5_on_st",      12'(state_o),  12'd1);
        strobe(1'b0, 12'h7FF);
        chk("t5_low_7ff",    12'(batt_low), 12'd1);
        strobe(1'b0, 12'h800);
        chk("t5_ok_800",     12'(batt_low), 12'd0);
        strobe(1'b0, 12'h7FF);
        chk("t5_low_again",  12'(batt_low), 12'd1);
        tick(4);
        chk("t5_hold",       12'(batt_low), 12'd1);
        press_btn();
        chk("t5_pend_hold",  12'(batt_low), 12'd1);
        rider_off = 1'b1;
        tick(1);
        chk("t5_off_st",     12'(state_o),  12'd0);
        chk("t5_off_clr",    12'(batt_low), 12'd0);
        rider_off = 1'b0;
        tick(1);

        // 6: asynchronous reset while in OVRSPD
        press_btn();
        strobe(1'b0, 12'h7FF);
        strobe(1'b1, 12'h7FF);
        strobe(1'b1, 12'h7FF);
        strobe(1'b1, 12'h7FF);
        strobe(1'b1, 12'h7FF);
        chk("t6_ovr_st",     12'(state_o),  12'd3);
        chk("t6_ovr_flag",   12'(ovr_spd),  12'd1);
        chk("t6_batt_low",   12'(batt_low), 12'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_pwr",    12'(pwr_up),   12'd0);
        chk("t6_rst_ovr",    12'(ovr_spd),  12'd0);
        chk("t6_rst_batt",   12'(batt_low), 12'd0);
        chk("t6_rst_st",     12'(state_o),  12'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
